// File: rtl/vga_seg_display_n.sv
// vga_seg_display_n: N-digit seven-segment display drawn on 640x480 VGA from a
// 50 MHz clock (two clocks per pixel). Bus writes land in shadow registers that
// are copied to the displayed set once per frame, at the end of active video.
// Optional feature macro: BLINK_EN (per-digit blink mask at register 9 plus a
// 6-bit frame counter; masked digits show all segments unlit when counter[5]=1).
module vga_seg_display_n #(
   parameter int          NUM_DIGITS = 8,
   parameter int          X0         = 128,
   parameter int          Y0         = 128,
   parameter logic [23:0] FG_RGB     = 24'hFF0000,
   parameter logic [23:0] DIM_RGB    = 24'h202020
) (
   input  logic       clk50,
   input  logic       reset_n,
   input  logic       chipselect,
   input  logic       write,
   input  logic [3:0] address,
   input  logic [7:0] writedata,
   output logic       frame_irq,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_n,
   output logic       VGA_SYNC_n
);

   localparam logic [10:0] H_ACT    = 11'd1280;
   localparam logic [10:0] H_SYNC_S = 11'd1312;
   localparam logic [10:0] H_SYNC_E = 11'd1503;
   localparam logic [10:0] H_LAST   = 11'd1599;
   localparam logic [9:0]  V_ACT    = 10'd480;
   localparam logic [9:0]  V_SYNC_S = 10'd490;
   localparam logic [9:0]  V_SYNC_E = 10'd491;
   localparam logic [9:0]  V_LAST   = 10'd524;
   localparam logic [9:0]  V_COMMIT = 10'd479;
   localparam logic [10:0] X0_W     = 11'(X0);
   localparam logic [10:0] SPAN_W   = 11'(128 * NUM_DIGITS);
   localparam logic [9:0]  Y0_W     = 10'(Y0);

   logic [10:0] hcount_q, hcount_d;
   logic [9:0]  vcount_q, vcount_d;
   logic        commit;
   logic        bus_wr;
   logic        en_q;
   logic [7:0]  blink_off;
   logic [7:0]  digit_bits [8];

   assign bus_wr = chipselect & write;
   // Last clock of the last active line: the whole frame has been drawn.
   assign commit = (hcount_q == H_LAST) && (vcount_q == V_COMMIT);

   // Raster counter next state: vcount steps when hcount wraps.
   always_comb begin
      hcount_d = hcount_q + 11'd1;
      vcount_d = vcount_q;
      if (hcount_q == H_LAST) begin
         hcount_d = '0;
         vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
      end
   end

   // Raster counters.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
      end
   end

   // Display enable; takes effect immediately, sync timing never depends on it.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         en_q <= 1'b1;
      end else if (bus_wr && address == 4'd8) begin
         en_q <= writedata[0];
      end
   end

`ifdef BLINK_EN
   logic [7:0] blink_shadow_q;
   logic [7:0] blink_active_q;
   logic [5:0] frame_cnt_q;

   // Blink mask is shadowed like the digits; frame counter ticks at each commit.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         blink_shadow_q <= '0;
         blink_active_q <= '0;
         frame_cnt_q    <= '0;
      end else begin
         if (bus_wr && address == 4'd9) begin
            blink_shadow_q <= writedata;
         end
         if (commit) begin
            blink_active_q <= blink_shadow_q;
            frame_cnt_q    <= frame_cnt_q + 6'd1;
         end
      end
   end

   assign blink_off = blink_active_q & {8{frame_cnt_q[5]}};
`else
   assign blink_off = 8'h00;
`endif

   // One shadow/active register pair per implemented digit; absent digits read zero.
   for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      if (gi < NUM_DIGITS) begin : g_live
         logic [7:0] shadow_q;
         logic [7:0] active_q;

         // A write in the commit cycle updates the shadow; the commit copies the old value.
         always_ff @(posedge clk50 or negedge reset_n) begin
            if (!reset_n) begin
               shadow_q <= '0;
               active_q <= '0;
            end else begin
               if (bus_wr && address == 4'(gi)) begin
                  shadow_q <= writedata;
               end
               if (commit) begin
                  active_q <= shadow_q;
               end
            end
         end

         assign digit_bits[gi] = blink_off[gi] ? 8'h00 : active_q;
      end else begin : g_absent
         assign digit_bits[gi] = 8'h00;
      end
   end

   logic [10:0] rel_x;
   logic [9:0]  rel_y;
   logic        in_active;
   logic        in_cell;
   logic [2:0]  cx;
   logic [3:0]  cy;
   logic [7:0]  seg_hit;
   logic [7:0]  cur_bits;
   logic [23:0] pix_rgb;

   // Map the raster position to a digit cell, a 8x16 coarse grid and the segments it covers.
   always_comb begin
      rel_x     = hcount_q - X0_W;
      rel_y     = vcount_q - Y0_W;
      in_active = (hcount_q < H_ACT) && (vcount_q < V_ACT);
      in_cell   = (hcount_q >= X0_W) && (rel_x < SPAN_W) &&
                  (vcount_q >= Y0_W) && (rel_y < 10'd128);
      cx        = rel_x[6:4];
      cy        = rel_y[6:3];
      cur_bits  = digit_bits[rel_x[9:7]];
      seg_hit[0] = (cy == 4'd0)  && (cx < 3'd6);
      seg_hit[1] = (cx == 3'd5)  && (cy <= 4'd6);
      seg_hit[2] = (cx == 3'd5)  && (cy >= 4'd6) && (cy <= 4'd12);
      seg_hit[3] = (cy == 4'd12) && (cx < 3'd6);
      seg_hit[4] = (cx == 3'd0)  && (cy >= 4'd6) && (cy <= 4'd12);
      seg_hit[5] = (cx == 3'd0)  && (cy <= 4'd6);
      seg_hit[6] = (cy == 4'd6)  && (cx < 3'd6);
      seg_hit[7] = (cx == 3'd6)  && (cy == 4'd14);
      pix_rgb = '0;
      if (in_active && in_cell && en_q) begin
         if (|(seg_hit & cur_bits)) begin
            pix_rgb = FG_RGB;
         end else if (|seg_hit) begin
            pix_rgb = DIM_RGB;
         end
      end
   end

   logic [23:0] rgb_q;
   logic        hs_q, vs_q, blank_n_q, sync_n_q, vga_clk_q, irq_q;

   // All VGA outputs registered one clock behind the counter state.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q     <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         sync_n_q  <= 1'b1;
         vga_clk_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         rgb_q     <= pix_rgb;
         hs_q      <= !((hcount_q >= H_SYNC_S) && (hcount_q <= H_SYNC_E));
         vs_q      <= !((vcount_q >= V_SYNC_S) && (vcount_q <= V_SYNC_E));
         blank_n_q <= in_active;
         sync_n_q  <= 1'b1;
         vga_clk_q <= hcount_q[0];
         irq_q     <= commit;
      end
   end

   assign VGA_R       = rgb_q[23:16];
   assign VGA_G       = rgb_q[15:8];
   assign VGA_B       = rgb_q[7:0];
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_n = blank_n_q;
   assign VGA_SYNC_n  = sync_n_q;
   assign VGA_CLK     = vga_clk_q;
   assign frame_irq   = irq_q;

endmodule

// File: tb/tb_vga_seg_display_n.sv
// Directed bench for vga_seg_display_n. After the free-running sync check the
// raster counters are pinned with force so single lines and the commit point
// can be reached without simulating whole frames.
module tb_vga_seg_display_n;

   localparam logic [23:0] FG  = 24'hFF0000;
   localparam logic [23:0] DIM = 24'h202020;
   localparam logic [23:0] BLK = 24'h000000;

   logic       clk50 = 1'b0;
   logic       reset_n = 1'b0;
   logic       chipselect = 1'b0;
   logic       write = 1'b0;
   logic [3:0] address = '0;
   logic [7:0] writedata = '0;

   logic       frame_irq, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       frame_irq4, VGA_CLK4, VGA_HS4, VGA_VS4, VGA_BLANK_n4, VGA_SYNC_n4;
   logic [7:0] VGA_R4, VGA_G4, VGA_B4;
   logic [23:0] rgb, rgb4;

   int checks = 0;
   int errors = 0;
   logic [10:0] fh;
   logic [9:0]  fv;

   always #10 clk50 = ~clk50;

   assign rgb  = {VGA_R, VGA_G, VGA_B};
   assign rgb4 = {VGA_R4, VGA_G4, VGA_B4};

   vga_seg_display_n dut (
      .clk50(clk50), .reset_n(reset_n), .chipselect(chipselect), .write(write),
      .address(address), .writedata(writedata), .frame_irq(frame_irq),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
   );

   vga_seg_display_n #(.NUM_DIGITS(4)) dut4 (
      .clk50(clk50), .reset_n(reset_n), .chipselect(chipselect), .write(write),
      .address(address), .writedata(writedata), .frame_irq(frame_irq4),
      .VGA_R(VGA_R4), .VGA_G(VGA_G4), .VGA_B(VGA_B4), .VGA_CLK(VGA_CLK4),
      .VGA_HS(VGA_HS4), .VGA_VS(VGA_VS4), .VGA_BLANK_n(VGA_BLANK_n4), .VGA_SYNC_n(VGA_SYNC_n4)
   );

   // Pin both raster counters to (h, v).
   task automatic goto(input logic [10:0] h, input logic [9:0] v);
      fh = h;
      fv = v;
      force dut.hcount_q  = fh;
      force dut.vcount_q  = fv;
      force dut4.hcount_q = fh;
      force dut4.vcount_q = fv;
   endtask

   // After this returns the registered outputs reflect position (h, v).
   task automatic probe(input logic [10:0] h, input logic [9:0] v);
      @(negedge clk50);
      goto(h, v);
      @(negedge clk50);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk50);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      $display("write addr=%0d data=%02h", a, d);
      @(negedge clk50);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic commit_frame();
      @(negedge clk50);
      goto(11'd1598, 10'd479);
      @(negedge clk50);
      checks++;
      if (frame_irq !== 1'b0) begin errors++; $display("FAIL irq_before got=%b want=0", frame_irq); end
      goto(11'd1599, 10'd479);
      @(negedge clk50);
      checks++;
      if (frame_irq !== 1'b1) begin errors++; $display("FAIL irq_pulse got=%b want=1", frame_irq); end
      goto(11'd0, 10'd0);
      @(negedge clk50);
      checks++;
      if (frame_irq !== 1'b0) begin errors++; $display("FAIL irq_after got=%b want=0", frame_irq); end
      $display("commit done");
   endtask

   task automatic test_reset();
      int first_low = 0, second_low = 0, hs_low_cnt = 0, vs_low_cnt = 0;
      logic clk_at2 = 1'b0, blank_at1 = 1'b0, blank_at1281 = 1'b1;
      repeat (3) @(negedge clk50);
      checks++;
      if ({rgb, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK, frame_irq} !== {24'h0, 6'b110100}) begin
         errors++;
         $display("FAIL reset_state got rgb=%h hs=%b vs=%b blank_n=%b sync_n=%b clk=%b irq=%b want 0/1/1/0/1/0/0",
                  rgb, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK, frame_irq);
      end
      reset_n = 1'b1;
      for (int n = 1; n <= 3000; n++) begin
         @(posedge clk50);
         #1;
         if (!VGA_HS && first_low == 0) first_low = n;
         if (!VGA_HS && n > 1600 && second_low == 0) second_low = n;
         if (!VGA_HS && n <= 1600) hs_low_cnt++;
         if (!VGA_VS) vs_low_cnt++;
         if (n == 1) blank_at1 = VGA_BLANK_n;
         if (n == 2) clk_at2 = VGA_CLK;
         if (n == 1281) blank_at1281 = VGA_BLANK_n;
      end
      $display("sync run first_low=%0d second_low=%0d hs_low=%0d", first_low, second_low, hs_low_cnt);
      checks++;
      if (first_low != 1313) begin errors++; $display("FAIL first_hs_low got=%0d want=1313", first_low); end
      checks++;
      if (second_low != 2913) begin errors++; $display("FAIL hs_period got=%0d want=2913", second_low); end
      checks++;
      if (hs_low_cnt != 192) begin errors++; $display("FAIL hs_width got=%0d want=192", hs_low_cnt); end
      checks++;
      if (vs_low_cnt != 0) begin errors++; $display("FAIL vs_early got=%0d want=0", vs_low_cnt); end
      checks++;
      if (blank_at1 !== 1'b1) begin errors++; $display("FAIL blank_first got=%b want=1", blank_at1); end
      checks++;
      if (blank_at1281 !== 1'b0) begin errors++; $display("FAIL blank_hfp got=%b want=0", blank_at1281); end
      checks++;
      if (clk_at2 !== 1'b1) begin errors++; $display("FAIL vga_clk got=%b want=1", clk_at2); end
   endtask

   task automatic test_sync_bounds();
      logic [10:0] hv [11] = '{11'd1311, 11'd1312, 11'd1503, 11'd1504, 11'd0, 11'd0,
                               11'd5, 11'd0, 11'd1279, 11'd0, 11'd100};
      logic [9:0]  vv [11] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd489, 10'd490,
                               10'd491, 10'd492, 10'd479, 10'd480, 10'd0};
      logic [2:0]  ev [11] = '{3'b110, 3'b010, 3'b010, 3'b110, 3'b110, 3'b100,
                               3'b100, 3'b110, 3'b111, 3'b110, 3'b111};
      for (int i = 0; i < 11; i++) begin
         probe(hv[i], vv[i]);
         $display("sync probe h=%0d v=%0d hs/vs/blank_n=%b", hv[i], vv[i], {VGA_HS, VGA_VS, VGA_BLANK_n});
         checks++;
         if ({VGA_HS, VGA_VS, VGA_BLANK_n} !== ev[i]) begin
            errors++;
            $display("FAIL sync_bound_%0d got=%b want=%b", i, {VGA_HS, VGA_VS, VGA_BLANK_n}, ev[i]);
         end
      end
   endtask

   task automatic test_digit_write();
      logic [10:0] hv [10] = '{11'd144, 11'd208, 11'd208, 11'd160, 11'd128, 11'd128,
                               11'd144, 11'd224, 11'd160, 11'd100};
      logic [9:0]  vv [10] = '{10'd128, 10'd144, 10'd208, 10'd224, 10'd208, 10'd144,
                               10'd176, 10'd240, 10'd144, 10'd128};
      logic [23:0] ev [10] = '{FG, FG, FG, FG, FG, FG, DIM, DIM, BLK, BLK};
      bus_write(4'd0, 8'h3F);
      probe(11'd144, 10'd128);
      checks++;
      if (rgb !== DIM) begin errors++; $display("FAIL before_commit got=%h want=%h", rgb, DIM); end
      commit_frame();
      for (int i = 0; i < 10; i++) begin
         probe(hv[i], vv[i]);
         $display("pixel h=%0d v=%0d rgb=%h", hv[i], vv[i], rgb);
         checks++;
         if (rgb !== ev[i]) begin errors++; $display("FAIL digit0_px%0d got=%h want=%h", i, rgb, ev[i]); end
      end
   endtask

   task automatic test_commit_edge();
      @(negedge clk50);
      goto(11'd1599, 10'd479);
      chipselect = 1'b1; write = 1'b1; address = 4'd3; writedata = 8'h01;
      $display("write addr=3 data=01 in commit cycle");
      @(negedge clk50);
      chipselect = 1'b0; write = 1'b0;
      goto(11'd0, 10'd0);
      checks++;
      if (frame_irq !== 1'b1) begin errors++; $display("FAIL edge_irq got=%b want=1", frame_irq); end
      probe(11'd528, 10'd128);
      checks++;
      if (rgb !== DIM) begin errors++; $display("FAIL edge_old_value got=%h want=%h", rgb, DIM); end
      commit_frame();
      probe(11'd528, 10'd128);
      checks++;
      if (rgb !== FG) begin errors++; $display("FAIL edge_new_value got=%h want=%h", rgb, FG); end
   endtask

   task automatic test_ctrl_and_unused();
      bus_write(4'd8, 8'h00);
      commit_frame();
      probe(11'd144, 10'd128);
      checks++;
      if (rgb !== BLK) begin errors++; $display("FAIL ctrl_off_lit got=%h want=%h", rgb, BLK); end
      probe(11'd144, 10'd176);
      checks++;
      if (rgb !== BLK) begin errors++; $display("FAIL ctrl_off_dim got=%h want=%h", rgb, BLK); end
      probe(11'd1312, 10'd0);
      checks++;
      if (VGA_HS !== 1'b0) begin errors++; $display("FAIL ctrl_off_hs got=%b want=0", VGA_HS); end
      probe(11'd0, 10'd490);
      checks++;
      if (VGA_VS !== 1'b0) begin errors++; $display("FAIL ctrl_off_vs got=%b want=0", VGA_VS); end
      bus_write(4'd8, 8'h01);
      bus_write(4'd12, 8'hFF);
`ifndef BLINK_EN
      bus_write(4'd9, 8'hFF);
`endif
      commit_frame();
      probe(11'd144, 10'd128);
      checks++;
      if (rgb !== FG) begin errors++; $display("FAIL ctrl_on_lit got=%h want=%h", rgb, FG); end
      probe(11'd144, 10'd176);
      checks++;
      if (rgb !== DIM) begin errors++; $display("FAIL unused_addr_d0 got=%h want=%h", rgb, DIM); end
      probe(11'd656, 10'd128);
      checks++;
      if (rgb !== DIM) begin errors++; $display("FAIL unused_addr_d4 got=%h want=%h", rgb, DIM); end
      probe(11'd272, 10'd176);
      checks++;
      if (rgb !== DIM) begin errors++; $display("FAIL unused_addr_d1 got=%h want=%h", rgb, DIM); end
   endtask

   task automatic test_num_digits();
      bus_write(4'd5, 8'hFF);
      commit_frame();
      probe(11'd784, 10'd128);
      checks++;
      if (rgb !== FG) begin errors++; $display("FAIL n8_digit5 got=%h want=%h", rgb, FG); end
      checks++;
      if (rgb4 !== BLK) begin errors++; $display("FAIL n4_digit5 got=%h want=%h", rgb4, BLK); end
      probe(11'd656, 10'd128);
      checks++;
      if (rgb4 !== BLK) begin errors++; $display("FAIL n4_digit4 got=%h want=%h", rgb4, BLK); end
      probe(11'd528, 10'd128);
      checks++;
      if (rgb4 !== FG) begin errors++; $display("FAIL n4_digit3 got=%h want=%h", rgb4, FG); end
   endtask

`ifdef BLINK_EN
   task automatic test_blink();
      logic [23:0] want;
      @(negedge clk50);
      reset_n = 1'b0;
      @(negedge clk50);
      reset_n = 1'b1;
      goto(11'd0, 10'd0);
      bus_write(4'd9, 8'h01);
      bus_write(4'd0, 8'hFF);
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk50);
         goto(11'd1599, 10'd479);
         @(negedge clk50);
         goto(11'd0, 10'd0);
         probe(11'd144, 10'd128);
         want = ((k % 64) < 32) ? FG : DIM;
         $display("blink frame=%0d rgb=%h", k, rgb);
         checks++;
         if (rgb !== want) begin errors++; $display("FAIL blink_frame%0d got=%h want=%h", k, rgb, want); end
      end
   endtask
`endif

   task automatic test_async_reset();
      probe(11'd145, 10'd128);
      checks++;
      if ({VGA_CLK, VGA_BLANK_n} !== 2'b11) begin
         errors++;
         $display("FAIL pre_reset got clk/blank=%b want=11", {VGA_CLK, VGA_BLANK_n});
      end
      #3;
      reset_n = 1'b0;
      #1;
      $display("async reset asserted rgb=%h", rgb);
      checks++;
      if ({rgb, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK, frame_irq} !== {24'h0, 6'b110100}) begin
         errors++;
         $display("FAIL async_reset got rgb=%h hs=%b vs=%b blank_n=%b sync_n=%b clk=%b irq=%b want 0/1/1/0/1/0/0",
                  rgb, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n, VGA_CLK, frame_irq);
      end
      @(negedge clk50);
      reset_n = 1'b1;
      probe(11'd144, 10'd128);
      checks++;
      if (rgb !== DIM) begin errors++; $display("FAIL post_reset_digits got=%h want=%h", rgb, DIM); end
   endtask

   initial begin
      test_reset();
      goto(11'd0, 10'd0);
      test_sync_bounds();
      test_digit_write();
      test_commit_edge();
      test_ctrl_and_unused();
      test_num_digits();
`ifdef BLINK_EN
      test_blink();
`endif
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
